// File: rtl/shift_pipe.sv
// shift_pipe: parametrised, pipelined log barrel shifter (SLL/SRL/SRA/ROR).
// A pipeline register follows every GROUP shift levels. Levels run largest
// shift first. Each operation carries an opaque tag and moves through the
// pipe under valid/ready flow control with back-pressure.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 2,
  parameter int TAGW  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]  in_amt,
  input  logic [1:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_zero
);

  localparam int NS = (SHW + GROUP - 1) / GROUP;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Stage registers; the last stage is the output register.
  logic            v_q   [NS];
  logic [WIDTH-1:0] d_q  [NS];
  logic [SHW-1:0]  amt_q [NS];
  logic [1:0]      op_q  [NS];
  logic            sgn_q [NS];
  logic [TAGW-1:0] tag_q [NS];
  logic            zero_q;

  // Inputs to each stage's level group, and the group's shifted result.
  logic            src_v   [NS];
  logic [WIDTH-1:0] src_d  [NS];
  logic [SHW-1:0]  src_amt [NS];
  logic [1:0]      src_op  [NS];
  logic            src_sgn [NS];
  logic [TAGW-1:0] src_tag [NS];
  logic [WIDTH-1:0] nxt_d  [NS];

  logic stall;

  // One log-shifter level: shift by sh. SRA fills with the original operand sign.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int unsigned sh,
                                                   input logic [1:0] op,
                                                   input logic sgn);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill;
    ones = '1;
    fill = sgn ? ~(ones >> sh) : '0;
    case (op)
      OP_SLL:  return d << sh;
      OP_SRL:  return d >> sh;
      OP_SRA:  return (d >> sh) | fill;
      default: return (d >> sh) | (d << (WIDTH - sh));
    endcase
  endfunction

  assign stall     = v_q[NS-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[NS-1];
  assign out_data  = d_q[NS-1];
  assign out_tag   = tag_q[NS-1];
  assign out_zero  = zero_q;

  // Route the input into stage 0 and each stage register into the next group.
  always_comb begin
    src_v[0]   = in_valid;
    src_d[0]   = in_data;
    src_amt[0] = in_amt;
    src_op[0]  = in_op;
    src_sgn[0] = in_data[WIDTH-1];
    src_tag[0] = in_tag;
    for (int unsigned s = 1; s < NS; s++) begin
      src_v[s]   = v_q[s-1];
      src_d[s]   = d_q[s-1];
      src_amt[s] = amt_q[s-1];
      src_op[s]  = op_q[s-1];
      src_sgn[s] = sgn_q[s-1];
      src_tag[s] = tag_q[s-1];
    end
  end

  // Apply each stage's GROUP levels, MSB level first; the last group may be short.
  always_comb begin
    int unsigned lvl;
    lvl = 0;
    for (int unsigned s = 0; s < NS; s++) begin
      nxt_d[s] = src_d[s];
      for (int unsigned j = 0; j < GROUP; j++) begin
        if (s * GROUP + j < SHW) begin
          lvl = SHW - 1 - (s * GROUP + j);
          if (src_amt[s][lvl])
            nxt_d[s] = shift_level(nxt_d[s], 32'd1 << lvl, src_op[s], src_sgn[s]);
        end
      end
    end
  end

  // Pipeline advance: flush kills all valids, stall freezes, otherwise shift by one.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned s = 0; s < NS; s++) begin
        v_q[s]   <= 1'b0;
        d_q[s]   <= '0;
        amt_q[s] <= '0;
        op_q[s]  <= '0;
        sgn_q[s] <= 1'b0;
        tag_q[s] <= '0;
      end
      zero_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned s = 0; s < NS; s++)
        v_q[s] <= 1'b0;
    end else if (!stall) begin
      for (int unsigned s = 0; s < NS; s++) begin
        v_q[s]   <= src_v[s];
        d_q[s]   <= nxt_d[s];
        amt_q[s] <= src_amt[s];
        op_q[s]  <= src_op[s];
        sgn_q[s] <= src_sgn[s];
        tag_q[s] <= src_tag[s];
      end
      zero_q <= (nxt_d[NS-1] == '0);
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe at three sizes: 32/2 (main), 8/1 and 64/6.
module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clrn, flush;

  // DUT A: WIDTH=32, GROUP=2 (NS=3)
  logic a_iv, a_ir, a_ov, a_or, a_oz;
  logic [31:0] a_id, a_od;
  logic [4:0]  a_ia;
  logic [1:0]  a_op;
  logic [3:0]  a_it, a_ot;
  // DUT B: WIDTH=8, GROUP=1 (NS=3)
  logic b_iv, b_ir, b_ov, b_or, b_oz;
  logic [7:0]  b_id, b_od;
  logic [2:0]  b_ia;
  logic [1:0]  b_op;
  logic [3:0]  b_it, b_ot;
  // DUT C: WIDTH=64, GROUP=6 (NS=1)
  logic c_iv, c_ir, c_ov, c_or, c_oz;
  logic [63:0] c_id, c_od;
  logic [5:0]  c_ia;
  logic [1:0]  c_op;
  logic [3:0]  c_it, c_ot;

  shift_pipe #(.WIDTH(32), .GROUP(2), .TAGW(4)) dut_a (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_amt(a_ia), .in_op(a_op), .in_tag(a_it),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_tag(a_ot), .out_zero(a_oz));

  shift_pipe #(.WIDTH(8), .GROUP(1), .TAGW(4)) dut_b (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_amt(b_ia), .in_op(b_op), .in_tag(b_it),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_tag(b_ot), .out_zero(b_oz));

  shift_pipe #(.WIDTH(64), .GROUP(6), .TAGW(4)) dut_c (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .in_amt(c_ia), .in_op(c_op), .in_tag(c_it),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_tag(c_ot), .out_zero(c_oz));

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int unsigned checks = 0;
  int unsigned errs   = 0;

  // Reference: each result bit is picked from the operand by the op's rule.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int unsigned amt,
                                            input logic [1:0] op, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      case (op)
        2'b00:   r[i] = (i >= amt) ? d[i - amt] : 1'b0;
        2'b01:   r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
        2'b10:   r[i] = (i + amt < w) ? d[i + amt] : d[w - 1];
        default: r[i] = d[(i + amt) % w];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic [4:0] amt,
                         input logic [1:0] op, input logic [3:0] t, input logic ordy,
                         input logic fl, input logic use_exp, input logic [31:0] exp_d,
                         output logic acc);
    exp_t e;
    @(negedge clk);
    flush = fl;
    a_iv = v; a_id = d; a_ia = amt; a_op = op; a_it = t; a_or = ordy;
    #1;
    acc = v & a_ir & ~fl;
    if (fl) qa.delete();
    if (acc) begin
      e.d = use_exp ? 64'(exp_d) : ref_shift(64'(d), 32'(amt), op, 32);
      e.t = t;
      qa.push_back(e);
    end
  endtask

  task automatic rand_a(input logic v, input logic ordy, input logic fl, output logic acc);
    drive_a(v, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ordy, fl, 1'b0, 32'h0, acc);
  endtask

  task automatic drive_bc(input logic bv, input logic [7:0] bd, input logic [2:0] ba,
                          input logic [1:0] bop, input logic [3:0] bt, input logic bor,
                          input logic b_use_exp, input logic [7:0] b_exp,
                          input logic cv, input logic [63:0] cd, input logic [5:0] ca,
                          input logic [1:0] cop, input logic [3:0] ct, input logic cor);
    exp_t e;
    @(negedge clk);
    flush = 1'b0;
    b_iv = bv; b_id = bd; b_ia = ba; b_op = bop; b_it = bt; b_or = bor;
    c_iv = cv; c_id = cd; c_ia = ca; c_op = cop; c_it = ct; c_or = cor;
    #1;
    if (bv && b_ir) begin
      e.d = b_use_exp ? 64'(b_exp) : ref_shift(64'(bd), 32'(ba), bop, 8);
      e.t = bt;
      qb.push_back(e);
    end
    if (cv && c_ir) begin
      e.d = ref_shift(cd, 32'(ca), cop, 64);
      e.t = ct;
      qc.push_back(e);
    end
  endtask

  task automatic rand_bc(input logic ordy_rand);
    drive_bc(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             ordy_rand ? 1'($urandom_range(0, 2) != 0) : 1'b1, 1'b0, 8'h0,
             1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 6'($urandom_range(0, 63)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             ordy_rand ? 1'($urandom_range(0, 2) != 0) : 1'b1);
  endtask

  // Monitors: pop and compare whenever a result transfers.
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (clrn && a_ov && a_or) begin
      if (qa.size() == 0) chk("a_unexpected_result", 64'(a_od), 64'hx);
      else begin
        e = qa.pop_front();
        chk("a_data", 64'(a_od), e.d);
        chk("a_tag", 64'(a_ot), 64'(e.t));
        chk("a_zero", 64'(a_oz), 64'(e.d == 64'h0));
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (clrn && b_ov && b_or) begin
      if (qb.size() == 0) chk("b_unexpected_result", 64'(b_od), 64'hx);
      else begin
        e = qb.pop_front();
        chk("b_data", 64'(b_od), e.d);
        chk("b_tag", 64'(b_ot), 64'(e.t));
        chk("b_zero", 64'(b_oz), 64'(e.d == 64'h0));
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (clrn && c_ov && c_or) begin
      if (qc.size() == 0) chk("c_unexpected_result", c_od, 64'hx);
      else begin
        e = qc.pop_front();
        chk("c_data", c_od, e.d);
        chk("c_tag", 64'(c_ot), 64'(e.t));
        chk("c_zero", 64'(c_oz), 64'(e.d == 64'h0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] sweep_exp [4];
  logic acc;
  int unsigned acc_cnt;

  initial begin
    sweep_exp[0] = 32'h0000_0F00;
    sweep_exp[1] = 32'h0800_000F;
    sweep_exp[2] = 32'hF800_000F;
    sweep_exp[3] = 32'h0800_000F;

    clrn = 1'b0; flush = 1'b0;
    a_iv = 0; a_id = '0; a_ia = '0; a_op = '0; a_it = '0; a_or = 1'b1;
    b_iv = 0; b_id = '0; b_ia = '0; b_op = '0; b_it = '0; b_or = 1'b1;
    c_iv = 0; c_id = '0; c_ia = '0; c_op = '0; c_it = '0; c_or = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(a_ov), 64'h0);
    chk("rst_out_data", 64'(a_od), 64'h0);
    chk("rst_out_tag", 64'(a_ot), 64'h0);
    chk("rst_out_zero", 64'(a_oz), 64'h0);
    chk("rst_in_ready", 64'(a_ir), 64'h1);
    @(negedge clk);
    clrn = 1'b1;

    // Latency: SLL 1 by 31, tag 5, result exactly 3 cycles later
    drive_a(1'b1, 32'h1, 5'd31, 2'b00, 4'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, acc);
    chk("lat_accept", 64'(acc), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0, acc);
      chk("lat_out_valid", 64'(a_ov), 64'(i == 3));
    end

    // Mode sweep with fixed expected results
    for (int op = 0; op < 4; op++)
      drive_a(1'b1, 32'h8000_00F0, 5'd4, 2'(op), 4'(op), 1'b1, 1'b0, 1'b1, sweep_exp[op], acc);
    drive_a(1'b1, 32'h0000_000F, 5'd4, 2'b11, 4'd9, 1'b1, 1'b0, 1'b1, 32'hF000_0000, acc);
    for (int op = 0; op < 4; op++)
      drive_a(1'b1, 32'h8000_00F0, 5'd0, 2'(op), 4'(op + 8), 1'b1, 1'b0, 1'b1, 32'h8000_00F0, acc);
    for (int i = 0; i < 5; i++) drive_a(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0, acc);
    chk("sweep_drained", 64'(qa.size()), 64'h0);

    // Back-to-back throughput: 8 ops, 8 consecutive results
    for (int i = 0; i < 12; i++) begin
      rand_a(1'(i < 8), 1'b1, 1'b0, acc);
      if (i < 8) chk("tp_in_ready", 64'(a_ir), 64'h1);
      chk("tp_out_valid", 64'(a_ov), 64'(i >= 3 && i < 11));
    end
    chk("tp_drained", 64'(qa.size()), 64'h0);

    // Back-pressure: fill with out_ready low, hold 5 cycles, release
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rand_a(1'b1, 1'b0, 1'b0, acc);
      if (acc) acc_cnt++;
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd3);
    for (int i = 0; i < 5; i++) begin
      rand_a(1'b1, 1'b0, 1'b0, acc);
      chk("bp_in_ready", 64'(a_ir), 64'h0);
      chk("bp_out_valid", 64'(a_ov), 64'h1);
      chk("bp_hold_data", 64'(a_od), qa[0].d);
      chk("bp_hold_tag", 64'(a_ot), 64'(qa[0].t));
    end
    for (int i = 0; i < 6; i++) rand_a(1'b0, 1'b1, 1'b0, acc);
    chk("bp_drained", 64'(qa.size()), 64'h0);

    // Random mix of valid and back-pressure
    for (int i = 0; i < 80; i++)
      rand_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) > 1), 1'b0, acc);
    for (int i = 0; i < 8; i++) rand_a(1'b0, 1'b1, 1'b0, acc);
    chk("mix_drained", 64'(qa.size()), 64'h0);

    // Flush with 3 ops in flight; the op offered with flush is dropped
    for (int i = 0; i < 3; i++) rand_a(1'b1, 1'b1, 1'b0, acc);
    rand_a(1'b1, 1'b0, 1'b1, acc);
    chk("flush_input_dropped", 64'(acc), 64'h0);
    for (int i = 0; i < 3; i++) begin
      rand_a(1'b0, 1'b1, 1'b0, acc);
      chk("flush_no_valid", 64'(a_ov), 64'h0);
    end
    rand_a(1'b1, 1'b1, 1'b0, acc);
    chk("post_flush_accept", 64'(acc), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      rand_a(1'b0, 1'b1, 1'b0, acc);
      chk("post_flush_latency", 64'(a_ov), 64'(i == 3));
    end
    for (int i = 0; i < 2; i++) rand_a(1'b0, 1'b1, 1'b0, acc);
    chk("flush_drained", 64'(qa.size()), 64'h0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++)
      drive_a(1'b1, $urandom | 32'h1, 5'($urandom_range(0, 31)), 2'b11, 4'hA, 1'b1,
              1'b0, 1'b0, '0, acc);
    @(negedge clk);
    a_iv = 1'b0;
    #3;
    clrn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_ov), 64'h0);
    chk("arst_out_data", 64'(a_od), 64'h0);
    chk("arst_out_tag", 64'(a_ot), 64'h0);
    chk("arst_out_zero", 64'(a_oz), 64'h0);
    qa.delete();
    @(negedge clk);
    clrn = 1'b1;
    rand_a(1'b1, 1'b1, 1'b0, acc);
    chk("arst_recover_accept", 64'(acc), 64'h1);
    for (int i = 0; i < 5; i++) rand_a(1'b0, 1'b1, 1'b0, acc);
    chk("arst_drained", 64'(qa.size()), 64'h0);

    // Parameter corners: SRA 0x80 by 7 at WIDTH=8; NS=3 for B and NS=1 for C
    drive_bc(1'b1, 8'h80, 3'd7, 2'b10, 4'd3, 1'b1, 1'b1, 8'hFF,
             1'b1, 64'h8000_0000_0000_0001, 6'd63, 2'b10, 4'd6, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      drive_bc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
      chk("w64_latency", 64'(c_ov), 64'(i == 1));
      chk("w8_latency", 64'(b_ov), 64'(i == 3));
    end
    for (int i = 0; i < 60; i++) rand_bc(1'(i >= 20));
    for (int i = 0; i < 8; i++)
      drive_bc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
    chk("w8_drained", 64'(qb.size()), 64'h0);
    chk("w64_drained", 64'(qc.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter; next generation of the single-cycle 32-bit mux shifter.
- Supports a generic power-of-two width and a configurable number of pipeline register stages.
- Adds a rotate mode, a pass-through tag and valid/ready flow control with back-pressure.
- Sits in the execute path as a multi-cycle functional unit, or as a standalone shift engine for DMA and bit-manipulation datapaths.

Parameters:
- WIDTH, 32, data width in bits; power of two, range 8..64.
- SHW, log2(WIDTH), shift-amount width; derived, not user-set.
- GROUP, 2, number of shift levels (mux ranks) between consecutive pipeline registers; range 1..SHW.
- TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk, in, 1: clock, rising edge.
- clrn, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous clear of all in-flight operations.
- in_valid, in, 1: input operation valid.
- in_ready, out, 1: unit accepts an input this cycle.
- in_data, in, WIDTH: operand to shift.
- in_amt, in, SHW: shift amount, 0..WIDTH-1.
- in_op, in, 2: operation; 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR (rotate right).
- in_tag, in, TAGW: tag returned unchanged with the result.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, WIDTH: shift result.
- out_tag, out, TAGW: tag of this result.
- out_zero, out, 1: out_data == 0.

Behaviour:
- Reset: clrn low asynchronously clears every stage valid bit, all stage data/amt/op/tag registers, out_data, out_tag and out_zero to 0. Only clrn is asynchronous.
- Structure: SHW log-shifter levels, level k shifts by 2^k. Level order is MSB first (largest shift first).
- A pipeline register follows every GROUP levels, and the final level group always ends in the output register.
- Number of stages is NS = ceil(SHW/GROUP). Latency from input acceptance to out_valid is exactly NS cycles.
- Each stage register carries: valid, partial data, remaining amount bits, op, tag.
- Per-level operation when amount bit k = 1:
  - SLL: fill zeros from the right.
  - SRL: fill zeros from the left.
  - SRA: fill with the original operand MSB, captured at input and carried down the pipe.
  - ROR: bits shifted out of the right re-enter on the left.
- When amount bit k = 0, the level passes data through unchanged.
- Amount 0 returns in_data unchanged for every op.
- Flow control: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A transfer occurs when in_valid & in_ready.
- When stall is high, every stage register holds its contents.
- When stall is low, all stages advance one position.
  - Stage 0 loads the input with valid = in_valid.
  - Bubbles (valid = 0) propagate like data and are not compressed.
- out_data, out_tag and out_zero are held stable while out_valid & ~out_ready.
- out_zero is registered together with out_data, never computed combinationally from out_data.
- flush: on the next edge, all stage valid bits and out_valid clear. flush overrides stall, and an input presented in the flush cycle is discarded. Data registers may keep stale values.
- Simultaneous input acceptance and output drain in the same cycle is legal; full throughput is one operation per cycle.
- in_amt bits beyond SHW do not exist; out-of-range amounts are impossible by construction.
- Invalid stages never assert out_valid, regardless of stale data.

Test Plan:
- Reset/latency (WIDTH=32, GROUP=2, NS=3): release clrn, then present one op SLL data=0x0000_0001 amt=31 tag=5 with out_ready=1. Required: out_valid rises exactly 3 cycles after acceptance, with out_data=0x8000_0000, out_tag=5, out_zero=0.
- Mode sweep, data=0x8000_00F0 amt=4:
  - SLL gives 0x0000_0F00.
  - SRL gives 0x0800_000F.
  - SRA gives 0xF800_000F.
  - ROR gives 0x0800_000F.
  - ROR with data=0x0000_000F amt=4 gives 0xF000_0000.
  - Amount 0 on all four ops returns 0x8000_00F0.
- Back-to-back throughput: stream 8 random ops with in_valid=1 and out_ready=1. Required: 8 consecutive out_valid cycles, results in order, each matching a reference model, and in_ready held at 1 throughout.
- Back-pressure: fill the pipe, then hold out_ready=0 for 5 cycles. Required: in_ready=0 during the hold, out_data/out_tag stable, no result lost or duplicated after release, and order preserved.
- Flush and reset mid-operation:
  - Assert flush with 3 ops in flight: no out_valid for those ops, and a new op accepted after flush emerges after NS cycles.
  - Pulse clrn low mid-stream: outputs go to 0 immediately (asynchronously).
- Parameter corners: WIDTH=8 with GROUP=1 (NS=3), and WIDTH=64 with GROUP=6 (NS=1). SRA of 0x80 by 7 at WIDTH=8 gives 0xFF, and the result checks against the model at both sizes.
